// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline with a multi-cycle MDU.
// Detects load-use and MDU-busy hazards, resolves branch/exception flushes,
// and drives write enables and flushes for the PC and the pipeline registers.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_mdu_rd,
  input  logic        id_mdu_op,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_is_div,
  input  logic        ex_branch_taken,
  input  logic        exc_req,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mdu_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       lu, mh, stall;

  assign mdu_busy = (state == BUSY);

  // Hazard detection; register $0 never creates a load-use dependency
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    mh = mdu_busy && (id_mdu_rd || id_mdu_op);
    stall = Rst && !exc_req && !ex_branch_taken && (lu || mh);
  end

  // MDU next-state: exception blocks a new start but never aborts a running op
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (ex_mdu_start && !exc_req) begin
          state_nx = BUSY;
          cnt_nx   = ex_mdu_is_div ? 8'(DIV_CYCLES - 1) : 8'(MULT_CYCLES - 1);
        end
      end
      BUSY: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write enables and flushes by priority: exception, branch, stall, default
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!Rst) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (exc_req) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu || mh) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // State, MDU counter and saturating stall counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_mdu_rd, id_mdu_op;
  logic        ex_mem_read, ex_mdu_start, ex_mdu_is_div, ex_branch_taken, exc_req;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mdu_busy;
  logic [15:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  // {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_flush
  localparam logic [8:0] O_RST   = 9'b00000_0000;
  localparam logic [8:0] O_DEF   = 9'b11111_0000;
  localparam logic [8:0] O_STALL = 9'b00111_0100;
  localparam logic [8:0] O_BR    = 9'b11111_1100;
  localparam logic [8:0] O_EXC   = 9'b11111_1110;

  logic [8:0] outs;
  assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_rd(id_mdu_rd), .id_mdu_op(id_mdu_op),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
    .ex_branch_taken(ex_branch_taken), .exc_req(exc_req),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_mdu_rd = 0; id_mdu_op = 0;
    ex_mem_read = 0; ex_mdu_start = 0; ex_mdu_is_div = 0;
    ex_branch_taken = 0; exc_req = 0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b0;
    #2;
    chk("rst_outs", 16'(outs), 16'(O_RST));
    chk("rst_busy", 16'(mdu_busy), 16'd0);
    chk("rst_scnt", stall_cnt, 16'd0);
    cyc(); cyc();
    Rst = 1'b1;
    #1;
    chk("def_outs", 16'(outs), 16'(O_DEF));

    // load-use on rs
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    #1 chk("lu_rs_outs", 16'(outs), 16'(O_STALL));
    cyc();
    chk("lu_rs_scnt", stall_cnt, 16'd1);

    // $0 never stalls
    ex_rd = 5'd0; id_rs = 5'd0;
    #1 chk("zero_outs", 16'(outs), 16'(O_DEF));
    cyc();
    chk("zero_scnt", stall_cnt, 16'd1);

    // match on rs but rs not used
    ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 0;
    #1 chk("unused_rs", 16'(outs), 16'(O_DEF));

    // load-use on rt
    id_rt = 5'd9; id_uses_rt = 1;
    #1 chk("lu_rt_outs", 16'(outs), 16'(O_STALL));
    cyc();
    chk("lu_rt_scnt", stall_cnt, 16'd2);

    // branch beats stall
    ex_branch_taken = 1;
    #1 chk("br_outs", 16'(outs), 16'(O_BR));
    cyc();
    chk("br_scnt", stall_cnt, 16'd2);

    // exception beats stall and cancels an MDU start
    idle_inputs();
    exc_req = 1; ex_mdu_start = 1; ex_mdu_is_div = 1;
    #1 chk("exc_outs", 16'(outs), 16'(O_EXC));
    cyc();
    chk("exc_nostart", 16'(mdu_busy), 16'd0);
    chk("exc_scnt", stall_cnt, 16'd2);

    // multiply: busy for MULT_CYCLES-1 = 3 cycles, exception mid-op does not abort
    idle_inputs();
    ex_mdu_start = 1;
    cyc();
    ex_mdu_start = 0;
    chk("mul_busy1", 16'(mdu_busy), 16'd1);
    chk("mul_nohaz", 16'(outs), 16'(O_DEF));
    exc_req = 1;
    #1 chk("mul_exc_outs", 16'(outs), 16'(O_EXC));
    cyc();
    exc_req = 0;
    chk("mul_busy2", 16'(mdu_busy), 16'd1);
    cyc();
    chk("mul_busy3", 16'(mdu_busy), 16'd1);
    cyc();
    chk("mul_done", 16'(mdu_busy), 16'd0);

    // divide: 31 busy/stall cycles with mfhi held in ID
    ex_mdu_start = 1; ex_mdu_is_div = 1;
    cyc();
    ex_mdu_start = 0; ex_mdu_is_div = 0; id_mdu_rd = 1;
    for (int i = 0; i < 31; i++) begin
      #1;
      chk("div_busy", 16'(mdu_busy), 16'd1);
      chk("div_stall", 16'(outs), 16'(O_STALL));
      cyc();
    end
    chk("div_done", 16'(mdu_busy), 16'd0);
    chk("div_release", 16'(outs), 16'(O_DEF));
    chk("div_scnt", stall_cnt, 16'd33);

    // mtlo-style op stalls while busy too
    idle_inputs();
    ex_mdu_start = 1; ex_mdu_is_div = 1;
    cyc();
    ex_mdu_start = 0; ex_mdu_is_div = 0; id_mdu_op = 1;
    #1 chk("op_stall", 16'(outs), 16'(O_STALL));
    cyc(); cyc();
    chk("op_scnt", stall_cnt, 16'd35);

    // asynchronous reset mid-BUSY, between edges
    #2 Rst = 1'b0;
    #1;
    chk("arst_busy", 16'(mdu_busy), 16'd0);
    chk("arst_scnt", stall_cnt, 16'd0);
    chk("arst_outs", 16'(outs), 16'(O_RST));
    idle_inputs();
    @(negedge Clk);
    Rst = 1'b1;
    cyc();
    chk("post_rst_busy", 16'(mdu_busy), 16'd0);
    chk("post_rst_outs", 16'(outs), 16'(O_DEF));

    // saturation of the stall counter
    ex_mem_read = 1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1;
    repeat (65540) @(posedge Clk);
    #1;
    chk("sat_scnt", stall_cnt, 16'hFFFF);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
